// File: rtl/float_stim_pkg.sv
// Shared types, encodings and the edge-case table for the float stimulus source.
// FLOAT_STIM_SPECIAL_EN widens the edge table with qNaN and the smallest denormal.
package float_stim_pkg;

  localparam logic [1:0] MODE_EDGE = 2'd0;
  localparam logic [1:0] MODE_RAND = 2'd1;
  localparam logic [1:0] MODE_MIX  = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  // Galois tap mask for x^32+x^22+x^2+x+1, right-shifting form
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

`ifdef FLOAT_STIM_SPECIAL_EN
  localparam int N_EDGE = 10;
`else
  localparam int N_EDGE = 8;
`endif

  // Built in 64 bits so a full 32-bit format never overflows the shifts
  function automatic logic [31:0] edge_value(input logic [3:0] idx, input int exp_w,
                                             input int man_w);
    logic [63:0] one, emax, mall, sgn, v;
    one  = 64'd1;
    emax = (one << exp_w) - one;
    mall = (one << man_w) - one;
    sgn  = one << (exp_w + man_w);
    case (idx)
      4'd0:    v = '0;
      4'd1:    v = sgn;
      4'd2:    v = (emax >> 1) << man_w;
      4'd3:    v = sgn | ((emax >> 1) << man_w);
      4'd4:    v = ((emax - one) << man_w) | mall;
      4'd5:    v = one << man_w;
      4'd6:    v = emax << man_w;
      4'd7:    v = sgn | (emax << man_w);
      4'd8:    v = (emax << man_w) | (one << (man_w - 1));
      4'd9:    v = one;
      default: v = '0;
    endcase
    return v[31:0];
  endfunction

endpackage

// File: rtl/float_stim_lfsr.sv
// Per-lane 32-bit Galois LFSR; advances only when step is high.
module float_stim_lfsr
  import float_stim_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [31:0] state
);

  always_ff @(posedge clk) begin
    if (rst)       state <= SEED;
    else if (step) state <= {1'b0, state[31:1]} ^ (state[0] ? LFSR_POLY : 32'h0);
  end

endmodule

// File: rtl/float_stimulus_gen.sv
// Multi-lane float operand source: edge sweep, random or mixed bursts over valid/ready.
// FLOAT_STIM_SPECIAL_EN adds NaN/denormal edge entries and removes the random exponent clamp.
module float_stimulus_gen
  import float_stim_pkg::*;
#(
  parameter int          EXP_W     = 8,
  parameter int          MAN_W     = 23,
  parameter int          CHANNELS  = 2,
  parameter int          START     = 0,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [1:0]                            mode,
  input  logic [15:0]                           count,
  output logic                                  num_valid,
  input  logic                                  num_ready,
  output logic [CHANNELS*(1+EXP_W+MAN_W)-1:0]   nums,
  output logic                                  busy,
  output logic                                  done
);

  localparam int W = 1 + EXP_W + MAN_W;

  state_t      state_q, state_d;
  logic [1:0]  mode_q, mode_sel;
  logic [15:0] count_q, beat_q;
  logic        go, accept, last, load, odd, use_rand;

  // num_valid is high for the whole RUN state, so acceptance only needs ready
  assign go       = (state_q == ST_IDLE) && start && (count != 16'd0);
  assign accept   = (state_q == ST_RUN) && num_ready;
  assign last     = (beat_q == count_q - 16'd1);
  assign load     = go || (accept && !last);
  assign mode_sel = go ? mode : mode_q;
  assign odd      = go ? 1'b0 : ~beat_q[0];
  assign use_rand = (mode_sel == MODE_RAND) || ((mode_sel == MODE_MIX) && odd);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (count == 16'd0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (accept && last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    num_valid = (state_q == ST_RUN);
    busy      = (state_q == ST_RUN);
    done      = (state_q == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MODE_EDGE;
      count_q <= '0;
      beat_q  <= '0;
    end else if (go) begin
      mode_q  <= mode;
      count_q <= count;
      beat_q  <= '0;
    end else if (accept) begin
      beat_q  <= beat_q + 16'd1;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    localparam logic [3:0] IDX0 = 4'((START + c) % N_EDGE);
    logic [3:0]   idx_q;
    logic [31:0]  lfsr_s, ev;
    logic [W-1:0] rv, lane_q;

    float_stim_lfsr #(.SEED(LFSR_SEED ^ 32'(c + 1))) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .step (load && use_rand),
      .state(lfsr_s)
    );

    assign ev = edge_value(idx_q, EXP_W, MAN_W);

    always_comb begin
      rv = lfsr_s[W-1:0];
`ifndef FLOAT_STIM_SPECIAL_EN
      // all-ones exponent minus one is just clearing its LSB
      if (&rv[W-2 -: EXP_W]) rv[MAN_W] = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        idx_q  <= IDX0;
        lane_q <= '0;
      end else if (load) begin
        if (use_rand) begin
          lane_q <= rv;
        end else begin
          lane_q <= ev[W-1:0];
          idx_q  <= (idx_q == 4'(N_EDGE - 1)) ? 4'd0 : idx_q + 4'd1;
        end
      end
    end

    assign nums[c*W +: W] = lane_q;
  end

endmodule
